jpeg_stream_packer: RTL and testbench
=====================================

JPEG_STREAM_PACKER -- requirements
Module: jpeg_stream_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the output word-address width.
REQ-002 SHALL have ports clk, input, 1, the clock; rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, a synchronous pulse that clears the block for a new image.
REQ-004 SHALL have ports in_data, input, 32, the encoder output word, and in_we, input, 4, its byte enables; bit3 qualifies [31:24].
REQ-005 SHALL have port in_last, input, 1, a pulse marking the end of the encoder stream.
REQ-006 SHALL have port in_ready, output, 1, meaning the holding register is free.
REQ-007 SHALL have ports out_data, output, 32; out_be, output, 4; out_valid, output, 1; out_ready, input, 1.
REQ-008 SHALL have ports out_addr, output, ADDR_W, the word index; done, output, 1, meaning the stream is complete.

Function
REQ-009 SHALL accept an input word when in_we!=0 and in_ready=1 and latch in_data/in_we into the holding register.
REQ-010 SHALL drive in_ready=1 only in state IDLE.
REQ-011 SHALL drop bytes whose enable is 0 and serialize enabled bytes MSB-first, at most one byte per cycle into the packing accumulator.
REQ-012 SHALL, when a serialized byte equals 0xFF, append 0x00 to the accumulator in the next byte slot (byte stuffing) before the next byte.
REQ-013 SHALL use FSM states IDLE -> SER -> IDLE per word; IDLE -> EOI_FF -> EOI_D9 -> FLUSH -> DONE after in_last.
REQ-014 SHALL capture in_last into a sticky flag in any state except DONE; any word accepted in the same cycle is processed first.
REQ-015 SHALL leave IDLE for EOI_FF only when the flag is set and the holding register is empty, and hold in_ready=0 from flag capture onward.
REQ-016 SHALL append 0xFF in EOI_FF and 0xD9 in EOI_D9, both unstuffed (EOI marker).
REQ-017 SHALL, in FLUSH, pad a nonempty accumulator with 0x00 to 4 bytes, set out_be to the real-byte mask (MSB-aligned, e.g. 4'b1100), and move to DONE; an empty accumulator moves to DONE directly.
REQ-018 SHALL pack bytes MSB-first into out_data[31:24]..[7:0], transferring to the single output register when the 4th byte enters and out_be=4'b1111.
REQ-019 SHALL hold out_data/out_be/out_valid stable while out_valid=1 and out_ready=0, and stall serialization (no byte appended) while the output register is full and the accumulator holds 3 bytes.
REQ-020 SHALL free the output register on out_valid&&out_ready, with a simultaneous refill permitted in the same cycle.
REQ-021 SHALL increment out_addr by 1 per output handshake, wrapping from 2^ADDR_W-1 to 0.
REQ-022 SHALL assert done in DONE once the output register is empty and hold it until start or rst.
REQ-023 SHALL, when 4 non-0xFF bytes are accepted at edge t with out_ready=1, raise out_valid after edge t+4.
REQ-024 SHALL, on start in any state, return to IDLE and clear the holding register, accumulator, output register, last flag, out_addr and done; inputs present in the start cycle are ignored.

Reset
REQ-025 SHALL, on rst, set in_ready=1, out_valid=0, out_data=0, out_be=0, out_addr=0, done=0, state IDLE, and clear the last flag.

Verification
REQ-026 SHALL cover this case: word 0x11223344 with we=F and out_ready=1 -> out_data=0x11223344, be=F, out_valid rises 4 cycles after accept, addr 0->1.
REQ-027 SHALL cover this case: word 0xAAFFBBCC with we=F -> first word 0xAAFF00BB; 0xCC remains in the accumulator; in_ready is low for 5 cycles.
REQ-028 SHALL cover this case: word 0x12345678 with we=4'b1010 -> bytes 0x12, 0x56 only; then in_last -> out word 0x1256FFD9, be=F, then done=1.
REQ-029 SHALL cover this case: a 1-byte 0x7F, then in_last -> final word 0x7FFFD900 with be=4'b1110, then done=1.
REQ-030 SHALL cover this case: out_ready held 0 for 10 cycles with two words pending -> out_data is stable and no byte is lost or duplicated after release.
REQ-031 SHALL cover this case: start asserted mid-SER, then a new word -> addr restarts at 0 and no bytes from the earlier word appear.

Source files
------------

// File: rtl/jpeg_stream_packer.sv
// JPEG entropy-stream packer: byte-stuffs encoder words, appends the EOI
// marker and repacks the stream into addressed 32-bit output words.
module jpeg_stream_packer #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       in_data,
    input  logic [3:0]        in_we,
    input  logic              in_last,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic [3:0]        out_be,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        SER,
        EOI_FF,
        EOI_D9,
        FLUSH,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       hold_data_q, hold_data_d;
    logic [3:0]        hold_we_q, hold_we_d;
    logic              stuff_q, stuff_d;
    logic              last_q, last_d;
    logic [23:0]       acc_q, acc_d;
    logic [1:0]        acc_cnt_q, acc_cnt_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [3:0]        out_be_q, out_be_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              done_q, done_d;
    logic              in_ready_q, in_ready_d;

    logic              out_free;
    logic              can_app;
    logic              app_en;
    logic [7:0]        app_byte;
    logic              flush_en;
    logic [7:0]        sel_byte;
    logic [3:0]        rem_we;
    logic [3:0]        flush_be;

    // Highest remaining enabled lane is the next byte out.
    always_comb begin
        sel_byte = hold_data_q[7:0];
        rem_we   = 4'b0000;
        if (hold_we_q[3]) begin
            sel_byte = hold_data_q[31:24];
            rem_we   = {1'b0, hold_we_q[2:0]};
        end else if (hold_we_q[2]) begin
            sel_byte = hold_data_q[23:16];
            rem_we   = {2'b00, hold_we_q[1:0]};
        end else if (hold_we_q[1]) begin
            sel_byte = hold_data_q[15:8];
            rem_we   = {3'b000, hold_we_q[0]};
        end
    end

    always_comb begin
        flush_be = 4'b1110;
        case (acc_cnt_q)
            2'd1:    flush_be = 4'b1000;
            2'd2:    flush_be = 4'b1100;
            default: flush_be = 4'b1110;
        endcase
    end

    assign out_free = !out_valid_q || out_ready;
    assign can_app  = (acc_cnt_q != 2'd3) || out_free;

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_we_d   = hold_we_q;
        stuff_d     = stuff_q;
        last_d      = last_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        out_data_d  = out_data_q;
        out_be_d    = out_be_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        app_en      = 1'b0;
        app_byte    = 8'h00;
        flush_en    = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_addr_d  = out_addr_q + 1'b1;
        end

        if (in_last && state_q != DONE) begin
            last_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_ready_q && in_we != 4'b0000) begin
                    hold_data_d = in_data;
                    hold_we_d   = in_we;
                    state_d     = SER;
                end else if (last_q) begin
                    state_d = EOI_FF;
                end
            end
            SER: begin
                if (can_app) begin
                    app_en = 1'b1;
                    if (stuff_q) begin
                        app_byte = 8'h00;
                        stuff_d  = 1'b0;
                        if (hold_we_q == 4'b0000) begin
                            state_d = IDLE;
                        end
                    end else begin
                        app_byte  = sel_byte;
                        hold_we_d = rem_we;
                        stuff_d   = (sel_byte == 8'hFF);
                        if (rem_we == 4'b0000 && sel_byte != 8'hFF) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            EOI_FF: begin
                if (can_app) begin
                    app_en   = 1'b1;
                    app_byte = 8'hFF;
                    state_d  = EOI_D9;
                end
            end
            EOI_D9: begin
                if (can_app) begin
                    app_en   = 1'b1;
                    app_byte = 8'hD9;
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                if (acc_cnt_q == 2'd0) begin
                    state_d = DONE;
                end else if (out_free) begin
                    flush_en = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The fourth byte completes a word and moves straight to the output.
        if (app_en) begin
            if (acc_cnt_q == 2'd3) begin
                out_data_d  = {acc_q, app_byte};
                out_be_d    = 4'b1111;
                out_valid_d = 1'b1;
                acc_d       = 24'h0;
                acc_cnt_d   = 2'd0;
            end else begin
                case (acc_cnt_q)
                    2'd0:    acc_d[23:16] = app_byte;
                    2'd1:    acc_d[15:8]  = app_byte;
                    default: acc_d[7:0]   = app_byte;
                endcase
                acc_cnt_d = acc_cnt_q + 2'd1;
            end
        end

        if (flush_en) begin
            out_data_d  = {acc_q, 8'h00};
            out_be_d    = flush_be;
            out_valid_d = 1'b1;
            acc_d       = 24'h0;
            acc_cnt_d   = 2'd0;
        end

        if (start) begin
            state_d     = IDLE;
            hold_data_d = 32'h0;
            hold_we_d   = 4'b0000;
            stuff_d     = 1'b0;
            last_d      = 1'b0;
            acc_d       = 24'h0;
            acc_cnt_d   = 2'd0;
            out_data_d  = 32'h0;
            out_be_d    = 4'b0000;
            out_valid_d = 1'b0;
            out_addr_d  = '0;
        end

        in_ready_d = (state_d == IDLE) && !last_d;
        done_d     = (state_d == DONE) && !out_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_data_q <= 32'h0;
            hold_we_q   <= 4'b0000;
            stuff_q     <= 1'b0;
            last_q      <= 1'b0;
            acc_q       <= 24'h0;
            acc_cnt_q   <= 2'd0;
            out_data_q  <= 32'h0;
            out_be_q    <= 4'b0000;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_we_q   <= hold_we_d;
            stuff_q     <= stuff_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            out_data_q  <= out_data_d;
            out_be_q    <= out_be_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_be    = out_be_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign done      = done_q;

endmodule

// File: tb/tb_jpeg_stream_packer.sv
// Bench for jpeg_stream_packer: directed cases plus a randomized stream
// checked against a byte-list model of stuffing, EOI and word packing.
`timescale 1ns/1ps
module tb_jpeg_stream_packer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   in_data;
    logic [3:0]    in_we;
    logic          in_last;
    logic          in_ready;
    logic [31:0]   out_data;
    logic [3:0]    out_be;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_addr;
    logic          done;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [31:0]   d;
        logic [3:0]    be;
        logic [AW-1:0] a;
    } rec_t;

    logic [7:0] mq[$];
    rec_t       cap[$];

    bit   rand_mode   = 1'b0;
    logic ready_force = 1'b1;

    logic        hold_p = 1'b0;
    logic [31:0] pd     = 32'h0;
    logic [3:0]  pb     = 4'h0;

    jpeg_stream_packer #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_we     (in_we),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_be    (out_be),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) begin
        #2;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Consumer side: stability while stalled, and capture of every handshake.
    always @(negedge clk) begin
        if (hold_p) begin
            chk("stable_valid", 32'(out_valid), 32'd1);
            chk("stable_data", out_data, pd);
            chk("stable_be", 32'(out_be), 32'(pb));
        end
        hold_p <= !rst && !start && out_valid && !out_ready;
        pd     <= out_data;
        pb     <= out_be;
        if (!rst && out_valid && out_ready)
            cap.push_back('{out_data, out_be, out_addr});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] we);
        int k = 0;
        while (!in_ready && k < 500) begin
            tick();
            k++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_data = d;
        in_we   = we;
        tick();
        in_we   = 4'h0;
        for (int i = 3; i >= 0; i--) begin
            if (we[i]) begin
                mq.push_back(d[8*i +: 8]);
                if (d[8*i +: 8] == 8'hFF) mq.push_back(8'h00);
            end
        end
    endtask

    task automatic send_last();
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        mq.push_back(8'hFF);
        mq.push_back(8'hD9);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        mq.delete();
        cap.delete();
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 3000) begin
            tick();
            k++;
        end
        chk("done", 32'(done), 32'd1);
    endtask

    task automatic compare_stream(input string tag, input bit fin);
        int n, nw, r, ne;
        logic [31:0] w;
        logic [3:0]  be;
        n  = mq.size();
        nw = n / 4;
        r  = n % 4;
        ne = nw + ((fin && r != 0) ? 1 : 0);
        chk({tag, "_count"}, 32'(cap.size()), 32'(ne));
        for (int i = 0; i < ne && i < cap.size(); i++) begin
            w  = 32'h0;
            be = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if (4*i + j < n) begin
                    w[31 - 8*j -: 8] = mq[4*i + j];
                    be[3 - j]        = 1'b1;
                end
            end
            chk($sformatf("%s_w%0d_data", tag, i), cap[i].d, w);
            chk($sformatf("%s_w%0d_be", tag, i), 32'(cap[i].be), 32'(be));
            chk($sformatf("%s_w%0d_addr", tag, i), 32'(cap[i].a),
                32'(i % (1 << AW)));
        end
    endtask

    initial begin
        int          lowc;
        logic [31:0] d;
        logic [3:0]  we;

        rst     = 1'b1;
        start   = 1'b0;
        in_data = 32'h0;
        in_we   = 4'h0;
        in_last = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_be", 32'(out_be), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        send_word(32'h11223344, 4'hF);
        repeat (3) tick();
        chk("lat_t3_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_t4_valid", 32'(out_valid), 32'd1);
        chk("lat_data", out_data, 32'h11223344);
        chk("lat_be", 32'(out_be), 32'hF);
        chk("lat_addr0", 32'(out_addr), 32'd0);
        tick();
        chk("lat_addr1", 32'(out_addr), 32'd1);
        send_last();
        wait_done();
        compare_stream("basic", 1'b1);

        do_start();
        chk("start_addr", 32'(out_addr), 32'd0);
        chk("start_done", 32'(done), 32'd0);
        send_word(32'hAAFFBBCC, 4'hF);
        lowc = 0;
        while (!in_ready && lowc < 50) begin
            lowc++;
            tick();
        end
        chk("stuff_ready_low", 32'(lowc), 32'd5);
        compare_stream("stuff_mid", 1'b0);
        send_last();
        wait_done();
        compare_stream("stuff", 1'b1);

        do_start();
        send_word(32'h12345678, 4'b1010);
        send_last();
        wait_done();
        compare_stream("sparse", 1'b1);
        repeat (3) tick();
        chk("done_hold", 32'(done), 32'd1);
        chk("done_no_valid", 32'(out_valid), 32'd0);

        do_start();
        send_word(32'h0000007F, 4'b0001);
        send_last();
        wait_done();
        compare_stream("onebyte", 1'b1);

        do_start();
        ready_force = 1'b0;
        send_word(32'h01020304, 4'hF);
        send_word(32'h05060708, 4'hF);
        repeat (10) tick();
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, 32'h01020304);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        ready_force = 1'b1;
        send_word(32'h090A0B0C, 4'b0110);
        send_last();
        wait_done();
        compare_stream("stall", 1'b1);

        do_start();
        send_word(32'h01020304, 4'hF);
        tick();
        do_start();
        chk("abort_addr", 32'(out_addr), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        send_word(32'hA1B2C3D4, 4'hF);
        send_last();
        wait_done();
        compare_stream("abort", 1'b1);

        do_start();
        rand_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int j = 0; j < 4; j++)
                d[8*j +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF
                                                          : 8'($urandom);
            we = 4'($urandom_range(1, 15));
            send_word(d, we);
        end
        send_last();
        wait_done();
        compare_stream("rand", 1'b1);
        rand_mode = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
